mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single DPI-backed data memory port between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Arbitrates, latches the winning request, and drives a valid/ready request channel toward memory.
- Routes the single response back to the owner, with a response timeout.
- Sits between the IFU/LSU and the memory-access wrapper; one outstanding transaction at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYC, 255, max cycles in WAIT before an error response; 8-bit counter, legal 1..255

Ports:
clk  in  1  clock; all state on rising edge
rstn  in  1  synchronous active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU fetch address
ifu_rsp_valid  out  1  IFU response pulse
ifu_rsp_data  out  DATA_W  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1=store, 0=load
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  4  byte mask: 1111 word, 0011 half, 0001 byte
lsu_rsp_valid  out  1  LSU response pulse; loads and stores
lsu_rsp_data  out  DATA_W  load data; 0 for stores
rsp_err  out  1  qualifies either rsp_valid; 1=timeout
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_wen  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_wmask  out  4  write mask; 0000 for reads
mem_rsp_valid  in  1  memory response
mem_rsp_data  in  DATA_W  memory read data

Behaviour:
- Clock port is clk; reset port is rstn. Reset is synchronous and active-low.
- On reset:
  - state=IDLE; owner=IFU; timeout counter=0; all latched request fields=0.
  - All outputs 0.
  - Any in-flight transaction is dropped; no response is issued for it.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Winner is chosen combinationally; default fixed priority, LSU over IFU.
  - The winner's ready is driven high for exactly that cycle; the loser's ready stays 0.
  - If either valid is high, latch the winner's fields and owner, then go to REQ.
  - IFU latch: wen=0, wmask=0000, wdata=0.
  - A requester must hold valid until its ready is seen.
- REQ:
  - mem_req_valid=1 with the latched fields, stable until mem_req_ready=1.
  - On handshake: clear counter, go to WAIT.
  - Both req_ready outputs are 0.
- WAIT:
  - Counter increments each cycle.
  - On mem_rsp_valid=1: next cycle, pulse the owner's rsp_valid for 1 cycle.
    - Owner rsp_data = mem_rsp_data for loads and fetches, 0 for stores; rsp_err=0.
    - Return to IDLE.
  - If counter reaches TIMEOUT_CYC with no response: next cycle, pulse owner rsp_valid with data=0 and rsp_err=1, then go to IDLE.
  - Response and timeout in the same cycle: the response wins, rsp_err=0.
- mem_rsp_valid outside WAIT is ignored.
- rsp_data holds its last value between pulses; rsp_err is 0 whenever no rsp_valid is high.
- Minimum latency (mem_req_ready=1, response in the first WAIT cycle):
  - accept cycle N;
  - mem_req_valid cycle N+1;
  - response in at N+2;
  - rsp_valid at N+3.
- A new request may be accepted in the same cycle its predecessor's rsp_valid pulses, since the block is back in IDLE.
- Counter never wraps; it saturates at TIMEOUT_CYC.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a 1-bit last-grant register, reset to IFU, updated on each grant.
  - When both requesters are valid, grant goes to the one not granted last.
  - A single valid requester always wins.
- Undefined: fixed LSU-over-IFU priority; no last-grant register.

Test Plan:
- Reset mid-WAIT (LSU load to 0x80000010 outstanding), then mem_rsp_valid -> no lsu_rsp_valid; all outputs 0; state IDLE.
- IFU fetch 0x80000000, mem_req_ready=1, response 0x00000413 in the first WAIT cycle -> ifu_rsp_valid at N+3 with data 0x00000413, rsp_err=0, mem_wmask=0000.
- LSU and IFU both valid in the same cycle, fixed priority -> lsu_req_ready=1, ifu_req_ready=0; IFU granted on the next IDLE.
  - With MEM_ARB_RR_EN, two back-to-back contentions -> grants LSU then IFU.
- LSU store addr 0x80001000, data 0xDEADBEEF, mask 0011, mem_req_ready low 3 cycles -> mem_* stable for 4 cycles; lsu_rsp_valid with data 0 after the response.
- TIMEOUT_CYC=4, no mem_rsp_valid -> owner rsp_valid with rsp_err=1, data 0, 5 cycles after entering WAIT; then IDLE.
  - Response in the exact timeout cycle -> normal response, rsp_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter (IFU fetch, LSU load/store) in front of a single memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic       OWN_IFU = 1'b0;
    localparam logic       OWN_LSU = 1'b1;
    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT_CYC);

    logic [1:0]        state;
    logic              owner;
    logic [7:0]        cnt;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wmask;

    logic grant_lsu;
    logic accept;
    logic rsp_hit;
    logic tmo_hit;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // Under contention the requester not served last time wins.
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant == OWN_IFU);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant <= OWN_IFU;
        end else if (accept) begin
            last_grant <= grant_lsu;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu_req_valid;
    end
`endif

    // Valid/ready: a request transfers in the cycle both valid and ready are high;
    // requesters hold valid and their fields until then. Ready is only offered in IDLE.
    always_comb begin
        accept        = rstn && (state == S_IDLE) && (ifu_req_valid || lsu_req_valid);
        lsu_req_ready = accept && grant_lsu;
        ifu_req_ready = accept && !grant_lsu;
        rsp_hit       = (state == S_WAIT) && mem_rsp_valid;
        tmo_hit       = (state == S_WAIT) && !mem_rsp_valid && (cnt == TMO_MAX);
    end

    always_comb begin
        mem_req_valid = (state == S_REQ);
        mem_wen       = req_wen;
        mem_addr      = req_addr;
        mem_wdata     = req_wdata;
        mem_wmask     = req_wmask;
        dbg_state     = state;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            owner         <= OWN_IFU;
            cnt           <= 8'd0;
            req_wen       <= 1'b0;
            req_addr      <= '0;
            req_wdata     <= '0;
            req_wmask     <= 4'b0000;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
            rsp_err       <= 1'b0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            rsp_err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner <= grant_lsu;
                        state <= S_REQ;
                        if (grant_lsu) begin
                            req_wen   <= lsu_wen;
                            req_addr  <= lsu_addr;
                            req_wdata <= lsu_wen ? lsu_wdata : '0;
                            req_wmask <= lsu_wen ? lsu_wmask : 4'b0000;
                        end else begin
                            req_wen   <= 1'b0;
                            req_addr  <= ifu_addr;
                            req_wdata <= '0;
                            req_wmask <= 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= 8'd0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_hit || tmo_hit) begin
                        // A response arriving on the timeout cycle still counts as a good response.
                        state   <= S_IDLE;
                        rsp_err <= tmo_hit;
                        if (owner == OWN_LSU) begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_data  <= (rsp_hit && !req_wen) ? mem_rsp_data : '0;
                        end else begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_data  <= rsp_hit ? mem_rsp_data : '0;
                        end
                    end else if (cnt != TMO_MAX) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT_CYC=4): reset, fetch latency, contention, stalled store, timeout.
module tb_mem_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
    logic [3:0]  lsu_wmask;
    logic        rsp_err;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [3:0]  mem_wmask;
    logic [1:0]  dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic exp_lsu2;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rstn(rstn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = 4'b0000;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    // Starts in the REQ cycle; returns in the cycle the owner's rsp_valid should pulse.
    task automatic serve(input int stall, input int delay, input logic [31:0] data);
        mem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < delay; i++) step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        step();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        idle_inputs();
        step(); step();
        total_cnt++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen, ifu_rsp_valid, lsu_rsp_valid, rsp_err} !== 7'b0) $display("FAIL reset_flags: got %b want 0", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen, ifu_rsp_valid, lsu_rsp_valid, rsp_err}); else pass_cnt++;
        total_cnt++; if ({mem_addr, mem_wdata, mem_wmask, ifu_rsp_data, lsu_rsp_data, dbg_state} !== '0) $display("FAIL reset_data: got nonzero, state %0d", dbg_state); else pass_cnt++;
        rstn = 1'b1;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0010; lsu_wmask = 4'b1111;
        #1;
        total_cnt++; if (lsu_req_ready !== 1'b1) $display("FAIL rst_lsu_ready: got %b want 1", lsu_req_ready); else pass_cnt++;
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        total_cnt++; if (mem_addr !== 32'h8000_0010 || mem_req_valid !== 1'b1) $display("FAIL rst_req: got addr %h valid %b want 80000010 1", mem_addr, mem_req_valid); else pass_cnt++;
        step();
        mem_req_ready = 1'b0;
        step();
        total_cnt++; if (dbg_state !== S_WAIT) $display("FAIL rst_in_wait: got state %0d want %0d", dbg_state, S_WAIT); else pass_cnt++;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
        #1;
        total_cnt++; if (dbg_state !== S_IDLE || mem_req_valid !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rst_mid_wait: got state %0d mreq %b addr %h want 0 0 0", dbg_state, mem_req_valid, mem_addr); else pass_cnt++;
        step();
        mem_rsp_valid = 1'b0;
        total_cnt++; if (lsu_rsp_valid !== 1'b0 || lsu_rsp_data !== 32'h0) $display("FAIL rst_dropped_rsp: got valid %b data %h want 0 0", lsu_rsp_valid, lsu_rsp_data); else pass_cnt++;
        step();
        total_cnt++; if (lsu_rsp_valid !== 1'b0 || dbg_state !== S_IDLE) $display("FAIL rst_stray_rsp: got valid %b state %0d want 0 0", lsu_rsp_valid, dbg_state); else pass_cnt++;
    endtask

    task automatic test_fetch;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        total_cnt++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) $display("FAIL fetch_ready: got ifu %b lsu %b want 1 0", ifu_req_ready, lsu_req_ready); else pass_cnt++;
        step();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        mem_req_ready = 1'b1;
        #1;
        total_cnt++; if ({mem_req_valid, mem_wen, mem_wmask} !== 6'b100000 || mem_addr !== 32'h8000_0000) $display("FAIL fetch_req: got v/wen/mask %b addr %h want 100000 80000000", {mem_req_valid, mem_wen, mem_wmask}, mem_addr); else pass_cnt++;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
        #1;
        total_cnt++; if (ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) $display("FAIL fetch_early: got rsp %b mreq %b want 0 0", ifu_rsp_valid, mem_req_valid); else pass_cnt++;
        step();
        mem_rsp_valid = 1'b0;
        total_cnt++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0000_0413 || rsp_err !== 1'b0 || lsu_rsp_valid !== 1'b0) $display("FAIL fetch_rsp: got v %b data %h err %b lsu %b want 1 00000413 0 0", ifu_rsp_valid, ifu_rsp_data, rsp_err, lsu_rsp_valid); else pass_cnt++;
        step();
        total_cnt++; if (ifu_rsp_valid !== 1'b0 || ifu_rsp_data !== 32'h0000_0413 || rsp_err !== 1'b0) $display("FAIL fetch_hold: got v %b data %h err %b want 0 00000413 0", ifu_rsp_valid, ifu_rsp_data, rsp_err); else pass_cnt++;
    endtask

    task automatic test_contention;
`ifdef MEM_ARB_RR_EN
        exp_lsu2 = 1'b0;
`else
        exp_lsu2 = 1'b1;
`endif
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0200; lsu_wmask = 4'b1111;
        #1;
        total_cnt++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) $display("FAIL cont1_ready: got lsu %b ifu %b want 1 0", lsu_req_ready, ifu_req_ready); else pass_cnt++;
        step();
        lsu_addr = 32'h8000_0204;
        #1;
        total_cnt++; if (mem_addr !== 32'h8000_0200 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) $display("FAIL cont1_req: got addr %h readies %b%b want 80000200 00", mem_addr, ifu_req_ready, lsu_req_ready); else pass_cnt++;
        serve(1, 0, 32'h1111_1111);
        total_cnt++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_data !== 32'h1111_1111 || ifu_rsp_valid !== 1'b0) $display("FAIL cont1_rsp: got v %b data %h ifu %b want 1 11111111 0", lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid); else pass_cnt++;
        total_cnt++; if (lsu_req_ready !== exp_lsu2 || ifu_req_ready !== !exp_lsu2) $display("FAIL cont2_ready: got lsu %b ifu %b want %b %b", lsu_req_ready, ifu_req_ready, exp_lsu2, !exp_lsu2); else pass_cnt++;
        step();
        if (exp_lsu2) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        #1;
        total_cnt++; if (mem_addr !== (exp_lsu2 ? 32'h8000_0204 : 32'h8000_0100)) $display("FAIL cont2_req: got addr %h want %h", mem_addr, exp_lsu2 ? 32'h8000_0204 : 32'h8000_0100); else pass_cnt++;
        serve(0, 1, 32'h2222_2222);
        total_cnt++; if ({lsu_rsp_valid, ifu_rsp_valid} !== {exp_lsu2, !exp_lsu2} || rsp_err !== 1'b0) $display("FAIL cont2_rsp: got lsu %b ifu %b err %b want %b %b 0", lsu_rsp_valid, ifu_rsp_valid, rsp_err, exp_lsu2, !exp_lsu2); else pass_cnt++;
        total_cnt++; if ({lsu_req_ready, ifu_req_ready} !== {!exp_lsu2, exp_lsu2}) $display("FAIL cont3_ready: got lsu %b ifu %b want %b %b", lsu_req_ready, ifu_req_ready, !exp_lsu2, exp_lsu2); else pass_cnt++;
        step();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        total_cnt++; if (mem_addr !== (exp_lsu2 ? 32'h8000_0100 : 32'h8000_0204)) $display("FAIL cont3_req: got addr %h want %h", mem_addr, exp_lsu2 ? 32'h8000_0100 : 32'h8000_0204); else pass_cnt++;
        serve(0, 0, 32'h3333_3333);
        total_cnt++; if ({lsu_rsp_valid, ifu_rsp_valid} !== {!exp_lsu2, exp_lsu2}) $display("FAIL cont3_rsp: got lsu %b ifu %b want %b %b", lsu_rsp_valid, ifu_rsp_valid, !exp_lsu2, exp_lsu2); else pass_cnt++;
        step();
    endtask

    task automatic test_store_stall;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        #1;
        total_cnt++; if (lsu_req_ready !== 1'b1) $display("FAIL store_ready: got %b want 1", lsu_req_ready); else pass_cnt++;
        step();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            total_cnt++; if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011}) $display("FAIL store_stable%0d: got v %b wen %b addr %h data %h mask %b want 1 1 80001000 deadbeef 0011", i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask); else pass_cnt++;
            step();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0;
        total_cnt++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_data !== 32'h0 || rsp_err !== 1'b0) $display("FAIL store_rsp: got v %b data %h err %b want 1 0 0", lsu_rsp_valid, lsu_rsp_data, rsp_err); else pass_cnt++;
        step();
    endtask

    task automatic test_timeout;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        total_cnt++; if (dbg_state !== S_WAIT) $display("FAIL tmo_wait: got state %0d want %0d", dbg_state, S_WAIT); else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            step();
            total_cnt++; if (ifu_rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("FAIL tmo_early%0d: got v %b err %b want 0 0", i, ifu_rsp_valid, rsp_err); else pass_cnt++;
        end
        step();
        total_cnt++; if (ifu_rsp_valid !== 1'b1 || rsp_err !== 1'b1 || ifu_rsp_data !== 32'h0 || dbg_state !== S_IDLE) $display("FAIL tmo_rsp: got v %b err %b data %h state %0d want 1 1 0 0", ifu_rsp_valid, rsp_err, ifu_rsp_data, dbg_state); else pass_cnt++;
        step();
        total_cnt++; if (ifu_rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("FAIL tmo_clear: got v %b err %b want 0 0", ifu_rsp_valid, rsp_err); else pass_cnt++;

        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0080; lsu_wmask = 4'b1111;
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        total_cnt++; if (lsu_rsp_valid !== 1'b1 || rsp_err !== 1'b0 || lsu_rsp_data !== 32'hCAFE_F00D) $display("FAIL tmo_race: got v %b err %b data %h want 1 0 cafef00d", lsu_rsp_valid, rsp_err, lsu_rsp_data); else pass_cnt++;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store_stall();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
